// File: rtl/div.sv
// Sequential signed divider: radix-2 restoring iteration on magnitudes, sign fix-up at the end.
// Quotient is returned on low and remainder on hi, matching the HI/LO read path of the multiplier.
module div #(
   parameter int bits = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [bits-1:0] a,
   input  logic [bits-1:0] b,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [bits-1:0] hi,
   output logic [bits-1:0] low,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(bits) + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [bits-1:0] mag_b_q, mag_b_d;
   logic [bits-1:0] quo_q, quo_d;
   logic [bits:0]   rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            div_zero_q, div_zero_d;
   logic [bits-1:0] hi_q, hi_d;
   logic [bits-1:0] low_q, low_d;

   // rem_q never exceeds |b|, so its top bit is zero and the trial difference
   // turns negative exactly when bit bits+1 is set.
   logic [bits+1:0] shifted;
   logic [bits+1:0] trial;

   assign shifted = {rem_q, quo_q[bits-1]};
   assign trial   = shifted - {2'b00, mag_b_q};

   always_comb begin
      state_d    = state_q;
      mag_b_d    = mag_b_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      low_d      = low_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               quo_d      = a[bits-1] ? -a : a;
               mag_b_d    = b[bits-1] ? -b : b;
               neg_quo_d  = a[bits-1] ^ b[bits-1];
               neg_rem_d  = a[bits-1];
               rem_d      = '0;
               cnt_d      = '0;
               div_zero_d = (b == '0);
               state_d    = (b == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            rem_d = trial[bits+1] ? shifted[bits:0] : trial[bits:0];
            quo_d = {quo_q[bits-2:0], ~trial[bits+1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(bits - 1)) state_d = FIX;
         end
         FIX: begin
            low_d   = neg_quo_q ? -quo_q : quo_q;
            hi_d    = neg_rem_q ? -rem_q[bits-1:0] : rem_q[bits-1:0];
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         mag_b_q    <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         low_q      <= '0;
      end else begin
         state_q    <= state_d;
         mag_b_q    <= mag_b_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         low_q      <= low_d;
      end
   end

   // Status decodes straight from the state register, so reset clears them without a clock edge.
   assign busy      = (state_q == RUN) || (state_q == FIX);
   assign done      = (state_q == DONE);
   assign div_zero  = div_zero_q;
   assign hi        = hi_q;
   assign low       = low_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: expected {low, hi, div_zero} are queued at start and compared at done.
module tb_div;

   localparam int W = 65;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, low;
   logic [1:0]  dbg_state;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   div #(.bits(32)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .low(low), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference: truncating division on magnitudes, quotient sign a^b, remainder sign a.
   function automatic logic [W-1:0] model(input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] ua, ub, q, r;
      ua = av[31] ? -av : av;
      ub = bv[31] ? -bv : bv;
      q  = ua / ub;
      r  = ua % ub;
      if (av[31] ^ bv[31]) q = -q;
      if (av[31]) r = -r;
      return {q, r, 1'b0};
   endfunction

   // Drives a one-cycle start; returns in cycle 1 with a/b scrambled.
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
   endtask

   // Waits (bounded) for done; cyc is the cycle number at which done is seen.
   task automatic wait_done(input int c0, output int cyc, output bit busy_err);
      cyc = c0; busy_err = 1'b0;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy !== 1'b1) busy_err = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      if (busy !== 1'b0) busy_err = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, div_zero, hi, low, dbg_state} !== '0)
         $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h low=%h st=%0d required all zero",
                  busy, done, div_zero, hi, low, dbg_state);
      else n_pass++;
      #3 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_signs;
      logic [31:0] ta[4] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
      logic [31:0] tb[4] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
      logic [31:0] tl[4] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3};
      logic [31:0] th[4] = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
      logic [W-1:0] e;
      int cyc;
      bit berr;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({tl[i], th[i], 1'b0});
         start_op(ta[i], tb[i]);
         wait_done(1, cyc, berr);
         n_checks++;
         if (cyc != 34) $display("FAIL signs_latency[%0d] got %0d required 34", i, cyc);
         else n_pass++;
         n_checks++;
         if (berr) $display("FAIL signs_busy[%0d] got busy profile wrong required high 1..33 low at done", i);
         else n_pass++;
         e = exp_q.pop_front();
         n_checks++;
         if ({low, hi, div_zero} !== e)
            $display("FAIL signs_result[%0d] got low=%h hi=%h dz=%b required low=%h hi=%h dz=%b",
                     i, low, hi, div_zero, e[64:33], e[32:1], e[0]);
         else n_pass++;
         @(posedge clk); #1;
         n_checks++;
         if (done !== 1'b0) $display("FAIL signs_done_pulse[%0d] got done=%b required 0", i, done);
         else n_pass++;
      end
   endtask

   task automatic test_overflow;
      logic [31:0] tb[2] = '{32'hFFFFFFFF, 32'd1};
      logic [W-1:0] e;
      int cyc;
      bit berr;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({32'h80000000, 32'h0, 1'b0});
         start_op(32'h80000000, tb[i]);
         wait_done(1, cyc, berr);
         e = exp_q.pop_front();
         n_checks++;
         if ({low, hi, div_zero} !== e || cyc != 34)
            $display("FAIL overflow[%0d] got low=%h hi=%h dz=%b cyc=%0d required low=%h hi=%h dz=%b cyc=34",
                     i, low, hi, div_zero, cyc, e[64:33], e[32:1], e[0]);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random;
      logic [31:0] av, bv;
      logic [W-1:0] e;
      int cyc;
      bit berr;
      for (int i = 0; i < 8; i++) begin
         av = $urandom;
         bv = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i % 2 == 1) bv = -bv;
         if (bv == '0) bv = 32'd5;
         exp_q.push_back(model(av, bv));
         start_op(av, bv);
         wait_done(1, cyc, berr);
         e = exp_q.pop_front();
         n_checks++;
         if ({low, hi, div_zero} !== e || cyc != 34)
            $display("FAIL random[%0d] a=%h b=%h got low=%h hi=%h dz=%b cyc=%0d required low=%h hi=%h dz=%b",
                     i, av, bv, low, hi, div_zero, cyc, e[64:33], e[32:1], e[0]);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div_zero;
      logic [W-1:0] e;
      int cyc;
      bit berr;
      exp_q.push_back({32'd14, 32'd2, 1'b0});
      start_op(32'd100, 32'd7);
      wait_done(1, cyc, berr);
      e = exp_q.pop_front();
      n_checks++;
      if ({low, hi, div_zero} !== e)
         $display("FAIL dz_preload got low=%h hi=%h dz=%b required low=%h hi=%h dz=%b",
                  low, hi, div_zero, e[64:33], e[32:1], e[0]);
      else n_pass++;
      @(posedge clk); #1;
      exp_q.push_back({32'd14, 32'd2, 1'b1});
      start_op(32'd5, 32'd0);
      wait_done(1, cyc, berr);
      n_checks++;
      if (cyc != 1 || berr) $display("FAIL dz_latency got cyc=%0d busy_err=%b required cyc=1 busy_err=0", cyc, berr);
      else n_pass++;
      e = exp_q.pop_front();
      n_checks++;
      if ({low, hi, div_zero} !== e)
         $display("FAIL dz_result got low=%h hi=%h dz=%b required low=%h hi=%h dz=%b",
                  low, hi, div_zero, e[64:33], e[32:1], e[0]);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (div_zero !== 1'b1 || done !== 1'b0)
         $display("FAIL dz_hold got dz=%b done=%b required dz=1 done=0", div_zero, done);
      else n_pass++;
      exp_q.push_back({32'd3, 32'd1, 1'b0});
      start_op(32'd7, 32'd2);
      n_checks++;
      if (div_zero !== 1'b0) $display("FAIL dz_clear got dz=%b required 0", div_zero);
      else n_pass++;
      wait_done(1, cyc, berr);
      e = exp_q.pop_front();
      n_checks++;
      if ({low, hi, div_zero} !== e || cyc != 34)
         $display("FAIL dz_after got low=%h hi=%h dz=%b cyc=%0d required low=%h hi=%h dz=%b cyc=34",
                  low, hi, div_zero, cyc, e[64:33], e[32:1], e[0]);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start_and_back_to_back;
      logic [W-1:0] e;
      int cyc;
      bit berr;
      exp_q.push_back({32'd333, 32'd1, 1'b0});
      start_op(32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(11, cyc, berr);
      e = exp_q.pop_front();
      n_checks++;
      if ({low, hi, div_zero} !== e || cyc != 34 || berr)
         $display("FAIL ignore_start got low=%h hi=%h dz=%b cyc=%0d busy_err=%b required low=%h hi=%h dz=%b cyc=34",
                  low, hi, div_zero, cyc, berr, e[64:33], e[32:1], e[0]);
      else n_pass++;
      @(posedge clk); #1;
      exp_q.push_back({32'd1, 32'd0, 1'b0});
      start_op(32'd9, 32'd9);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b required 1", busy);
      else n_pass++;
      wait_done(1, cyc, berr);
      e = exp_q.pop_front();
      n_checks++;
      if ({low, hi, div_zero} !== e || cyc != 34)
         $display("FAIL b2b_result got low=%h hi=%h dz=%b cyc=%0d required low=%h hi=%h dz=%b cyc=34",
                  low, hi, div_zero, cyc, e[64:33], e[32:1], e[0]);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run;
      logic [W-1:0] e;
      int cyc;
      bit berr;
      start_op(32'hFFFFFFFF, 32'h10);
      repeat (14) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1 || low !== 32'd1) $display("FAIL abort_pre got busy=%b low=%h required busy=1 low=1", busy, low);
      else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, hi, low, dbg_state} !== '0)
         $display("FAIL abort_async got busy=%b done=%b hi=%h low=%h st=%0d required all zero",
                  busy, done, hi, low, dbg_state);
      else n_pass++;
      @(posedge clk);
      #3 reset = 1'b0;
      exp_q.push_back({32'd8, 32'd0, 1'b0});
      start_op(32'd64, 32'd8);
      wait_done(1, cyc, berr);
      e = exp_q.pop_front();
      n_checks++;
      if ({low, hi, div_zero} !== e || cyc != 34)
         $display("FAIL abort_after got low=%h hi=%h dz=%b cyc=%0d required low=%h hi=%h dz=%b cyc=34",
                  low, hi, div_zero, cyc, e[64:33], e[32:1], e[0]);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_signs();
      test_overflow();
      test_random();
      test_div_zero();
      test_ignore_start_and_back_to_back();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
